// File: rtl/axi4_lite_arbiter_2to1.sv
// Two AXI4-lite masters sharing one AXI4-lite slave, one transaction in flight, registered grant.
// Define AXI_ARB_FIXED_PRIO_EN for fixed priority (master 0 wins ties) instead of round-robin.
module axi4_lite_arbiter_2to1 #(
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          s_awvalid,
    output logic [1:0]          s_awready,
    input  logic [2*ADDR_W-1:0] s_awaddr,
    input  logic [1:0]          s_wvalid,
    output logic [1:0]          s_wready,
    input  logic [63:0]         s_wdata,
    input  logic [7:0]          s_wstrb,
    output logic [1:0]          s_bvalid,
    input  logic [1:0]          s_bready,
    input  logic [1:0]          s_arvalid,
    output logic [1:0]          s_arready,
    input  logic [2*ADDR_W-1:0] s_araddr,
    input  logic [5:0]          s_arprot,
    output logic [1:0]          s_rvalid,
    input  logic [1:0]          s_rready,
    output logic [31:0]         s_rdata,
    output logic                m_awvalid,
    input  logic                m_awready,
    output logic [ADDR_W-1:0]   m_awaddr,
    output logic                m_wvalid,
    input  logic                m_wready,
    output logic [31:0]         m_wdata,
    output logic [3:0]          m_wstrb,
    input  logic                m_bvalid,
    output logic                m_bready,
    output logic                m_arvalid,
    input  logic                m_arready,
    output logic [ADDR_W-1:0]   m_araddr,
    output logic [2:0]          m_arprot,
    input  logic                m_rvalid,
    output logic                m_rready,
    input  logic [31:0]         m_rdata
);

    // state   | meaning
    // IDLE    | no grant; arbitrate pending requests
    // RD_ADDR | AR of granted master forwarded
    // RD_DATA | R forwarded to granted master
    // WR_ADDR | AW and W forwarded independently until both done
    // WR_RESP | B forwarded to granted master
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_ADDR = 3'd3,
        WR_RESP = 3'd4
    } state_t;

    state_t     state, state_nxt;
    logic       grant, grant_nxt;
    logic       aw_done, aw_done_nxt;
    logic       w_done, w_done_nxt;
    logic       aw_hs, w_hs;
    logic       winner;
    logic [1:0] req;
    logic [1:0] grant_oh;

    assign req      = s_arvalid | s_awvalid;
    assign grant_oh = {grant, ~grant};

    assign m_awaddr = grant ? s_awaddr[2*ADDR_W-1:ADDR_W] : s_awaddr[ADDR_W-1:0];
    assign m_araddr = grant ? s_araddr[2*ADDR_W-1:ADDR_W] : s_araddr[ADDR_W-1:0];
    assign m_arprot = grant ? s_arprot[5:3] : s_arprot[2:0];
    assign m_wdata  = grant ? s_wdata[63:32] : s_wdata[31:0];
    assign m_wstrb  = grant ? s_wstrb[7:4] : s_wstrb[3:0];

`ifdef AXI_ARB_FIXED_PRIO_EN
    // master 1 only wins when it is the sole requester
    assign winner = ~req[0];
`else
    logic last_grant;

    always_comb begin
        case (req)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            default: winner = ~last_grant;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_grant <= 1'b1;
        else if ((state == RD_DATA && m_rvalid && m_rready) ||
                 (state == WR_RESP && m_bvalid && m_bready))
            last_grant <= grant;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            grant   <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            state   <= state_nxt;
            grant   <= grant_nxt;
            aw_done <= aw_done_nxt;
            w_done  <= w_done_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        grant_nxt   = grant;
        aw_done_nxt = aw_done;
        w_done_nxt  = w_done;
        aw_hs       = 1'b0;
        w_hs        = 1'b0;
        m_awvalid   = 1'b0;
        m_wvalid    = 1'b0;
        m_bready    = 1'b0;
        m_arvalid   = 1'b0;
        m_rready    = 1'b0;
        s_awready   = 2'b00;
        s_wready    = 2'b00;
        s_bvalid    = 2'b00;
        s_arready   = 2'b00;
        s_rvalid    = 2'b00;
        s_rdata     = 32'h0;

        case (state)
            IDLE: begin
                if (|req) begin
                    grant_nxt = winner;
                    state_nxt = s_arvalid[winner] ? RD_ADDR : WR_ADDR;
                end
            end
            RD_ADDR: begin
                m_arvalid = s_arvalid[grant];
                s_arready = grant_oh & {2{m_arready}};
                if (m_arvalid && m_arready)
                    state_nxt = RD_DATA;
            end
            RD_DATA: begin
                s_rvalid = grant_oh & {2{m_rvalid}};
                s_rdata  = m_rdata;
                m_rready = s_rready[grant];
                if (m_rvalid && m_rready)
                    state_nxt = IDLE;
            end
            WR_ADDR: begin
                // a channel that already handshook is fenced off so it cannot repeat
                m_awvalid = s_awvalid[grant] & ~aw_done;
                s_awready = grant_oh & {2{m_awready & ~aw_done}};
                m_wvalid  = s_wvalid[grant] & ~w_done;
                s_wready  = grant_oh & {2{m_wready & ~w_done}};
                aw_hs     = m_awvalid & m_awready;
                w_hs      = m_wvalid & m_wready;
                if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                    state_nxt   = WR_RESP;
                    aw_done_nxt = 1'b0;
                    w_done_nxt  = 1'b0;
                end else begin
                    aw_done_nxt = aw_done | aw_hs;
                    w_done_nxt  = w_done | w_hs;
                end
            end
            WR_RESP: begin
                s_bvalid = grant_oh & {2{m_bvalid}};
                m_bready = s_bready[grant];
                if (m_bvalid && m_bready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi4_lite_arbiter_2to1.sv
// Directed bench for axi4_lite_arbiter_2to1 with a small zero-wait memory model behind it.
// Build with AXI_ARB_FIXED_PRIO_EN defined to check the fixed-priority variant.
module tb_axi4_lite_arbiter_2to1;

    logic        clk;
    logic        rst;
    logic [1:0]  s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic [1:0]  s_arvalid, s_arready, s_rvalid, s_rready;
    logic [63:0] s_awaddr, s_araddr, s_wdata;
    logic [7:0]  s_wstrb;
    logic [5:0]  s_arprot;
    logic [31:0] s_rdata;
    logic        m_awvalid, m_awready, m_wvalid, m_bvalid, m_bready;
    logic        m_arvalid, m_rvalid, m_rready;
    logic [31:0] m_awaddr, m_araddr, m_wdata, m_rdata;
    logic [3:0]  m_wstrb;
    logic [2:0]  m_arprot;
    logic        mem_aw_rdy;

    axi4_lite_arbiter_2to1 #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arprot(s_arprot),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
        .m_wvalid(m_wvalid), .m_wready(1'b1), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_arvalid(m_arvalid), .m_arready(1'b1), .m_araddr(m_araddr), .m_arprot(m_arprot),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata)
    );

    assign m_awready = mem_aw_rdy;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory model: 256 words, read data one cycle after AR, B in the cycle after AW and W are both seen
    logic [31:0] mem [0:255];
    logic        aw_got, w_got;
    logic [31:0] aw_addr_q, w_data_q;
    logic [3:0]  w_strb_q;
    logic        aw_now, w_now;
    logic [31:0] wr_addr, wr_data;
    logic [3:0]  wr_strb;

    assign aw_now  = aw_got | (m_awvalid & m_awready);
    assign w_now   = w_got | (m_wvalid & 1'b1);
    assign wr_addr = aw_got ? aw_addr_q : m_awaddr;
    assign wr_data = w_got ? w_data_q : m_wdata;
    assign wr_strb = w_got ? w_strb_q : m_wstrb;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h5555_0000 | i;
            mem[4]    <= 32'hDEAD_BEEF;
            mem[8]    <= 32'hAAAA_BBBB;
            m_rvalid  <= 1'b0;
            m_rdata   <= 32'h0;
            m_bvalid  <= 1'b0;
            aw_got    <= 1'b0;
            w_got     <= 1'b0;
            aw_addr_q <= 32'h0;
            w_data_q  <= 32'h0;
            w_strb_q  <= 4'h0;
        end else begin
            if (m_arvalid) begin
                m_rvalid <= 1'b1;
                m_rdata  <= mem[m_araddr[9:2]];
            end else if (m_rvalid && m_rready) begin
                m_rvalid <= 1'b0;
            end
            if (aw_now && w_now && !m_bvalid) begin
                for (int b = 0; b < 4; b++)
                    if (wr_strb[b]) mem[wr_addr[9:2]][b*8 +: 8] <= wr_data[b*8 +: 8];
                m_bvalid <= 1'b1;
                aw_got   <= 1'b0;
                w_got    <= 1'b0;
            end else begin
                if (m_awvalid && m_awready) begin
                    aw_got    <= 1'b1;
                    aw_addr_q <= m_awaddr;
                end
                if (m_wvalid) begin
                    w_got    <= 1'b1;
                    w_data_q <= m_wdata;
                    w_strb_q <= m_wstrb;
                end
                if (m_bvalid && m_bready) m_bvalid <= 1'b0;
            end
        end
    end

    logic [14:0] outs;
    assign outs = {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready,
                   s_awready, s_wready, s_bvalid, s_arready, s_rvalid};

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: observed %0h required %0h", tag, got, exp);
        end
    endtask

    logic [1:0]  pend_ar, pend_aw, pend_w, pend_r, pend_b;
    int          rhold0, rereq0, aw_rdy_from;
    int          cyc_ar [2], cyc_aw [2], cyc_w [2], cyc_r [2], cyc_b [2];
    logic [31:0] trc_mar, trc_maw, trc_mw, trc_rv1;
    logic [31:0] addr_c1, hold_exp;
    logic [2:0]  prot_c1;
    int          ord_q [$];
    logic [31:0] dat_q [$];

    task automatic drive_pend();
        s_arvalid = pend_ar;
        s_awvalid = pend_aw;
        s_wvalid  = pend_w;
        s_bready  = pend_b;
        s_rready  = pend_r & {1'b1, rhold0 == 0};
    endtask

    // runs every pending channel of both masters to completion; cycle 0 is the first cycle requests are visible
    task automatic engine(input int budget);
        logic [1:0] hs_ar, hs_aw, hs_w, hs_r, hs_b;
        ord_q.delete();
        dat_q.delete();
        trc_mar = '0; trc_maw = '0; trc_mw = '0; trc_rv1 = '0;
        for (int n = 0; n < 2; n++) begin
            cyc_ar[n] = -1; cyc_aw[n] = -1; cyc_w[n] = -1; cyc_r[n] = -1; cyc_b[n] = -1;
        end
        mem_aw_rdy = (aw_rdy_from <= 0);
        drive_pend();
        for (int c = 0; c < budget; c++) begin
            if ((pend_ar | pend_aw | pend_w | pend_r | pend_b) == 2'b00) break;
            @(negedge clk);
            hs_ar = s_arvalid & s_arready;
            hs_aw = s_awvalid & s_awready;
            hs_w  = s_wvalid & s_wready;
            hs_r  = s_rvalid & s_rready;
            hs_b  = s_bvalid & s_bready;
            if (c < 32) begin
                trc_mar[c] = m_arvalid;
                trc_maw[c] = m_awvalid;
                trc_mw[c]  = m_wvalid;
                trc_rv1[c] = s_rvalid[1];
            end
            if (c == 1) begin
                addr_c1 = m_araddr;
                prot_c1 = m_arprot;
            end
            for (int n = 0; n < 2; n++) begin
                if (hs_ar[n]) cyc_ar[n] = c;
                if (hs_aw[n]) cyc_aw[n] = c;
                if (hs_w[n])  cyc_w[n]  = c;
                if (hs_b[n])  cyc_b[n]  = c;
                if (hs_r[n]) begin
                    cyc_r[n] = c;
                    ord_q.push_back(n);
                    dat_q.push_back(s_rdata);
                end
            end
            if (s_rvalid[0] && rhold0 > 0) begin
                chk("rd_hold", {s_rdata, s_arready[1], s_rvalid[1], m_arvalid}, {hold_exp, 3'b000});
                rhold0--;
            end
            @(posedge clk); #1;
            pend_ar &= ~hs_ar;
            pend_aw &= ~hs_aw;
            pend_w  &= ~hs_w;
            pend_r  &= ~hs_r;
            pend_b  &= ~hs_b;
            if (hs_r[0] && rereq0 > 0) begin
                pend_ar[0] = 1'b1;
                pend_r[0]  = 1'b1;
                rereq0--;
            end
            mem_aw_rdy = (c + 1 >= aw_rdy_from);
            drive_pend();
        end
        chk("txn_timeout", {pend_ar, pend_aw, pend_w, pend_r, pend_b}, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pend_ar = '0; pend_aw = '0; pend_w = '0; pend_r = '0; pend_b = '0;
        rhold0 = 0; rereq0 = 0; aw_rdy_from = 0;
        drive_pend();
        @(posedge clk); @(posedge clk); #1;
        chk("rst_outs", {17'h0, outs}, 0);
        rst = 1'b0;
    endtask

    int          exp_o [3];
    logic        got_b;

    initial begin
        rst = 1'b1;
        mem_aw_rdy = 1'b1;
        s_awaddr = '0; s_araddr = '0; s_wdata = '0; s_wstrb = '0;
        s_arprot = {3'b001, 3'b100};
        s_awvalid = '0; s_wvalid = '0; s_bready = '0; s_arvalid = '0; s_rready = '0;

        // master 0 alone reads 0x10
        do_reset();
        s_araddr[31:0] = 32'h0000_0010;
        pend_ar = 2'b01; pend_r = 2'b01;
        engine(40);
        chk("ar_lat_c0", trc_mar[0], 1'b0);
        chk("ar_lat_c1", trc_mar[1], 1'b1);
        chk("ar_addr", addr_c1, 32'h0000_0010);
        chk("ar_prot", prot_c1, 3'b100);
        chk("rd_cycle", cyc_r[0], 2);
        chk("rd_data", dat_q[0], 32'hDEAD_BEEF);
        chk("rv1_quiet", trc_rv1, 0);

        // both masters read after reset, master 0 re-requests once
        do_reset();
        s_araddr[63:32] = 32'h0000_0014;
`ifdef AXI_ARB_FIXED_PRIO_EN
        exp_o = '{0, 0, 1};
`else
        exp_o = '{0, 1, 0};
`endif
        pend_ar = 2'b11; pend_r = 2'b11; rereq0 = 1;
        engine(40);
        chk("rr_count", ord_q.size(), 3);
        for (int i = 0; i < 3; i++) begin
            chk("rr_order", ord_q[i], exp_o[i]);
            chk("rr_data", dat_q[i], (exp_o[i] == 0) ? 32'hDEAD_BEEF : 32'h5555_0005);
        end

        // master 1 writes 0x20, W raised two cycles before AW, AW accepted late
        s_wdata[63:32] = 32'h1234_5678;
        s_wstrb[7:4]   = 4'b0011;
        s_awaddr[63:32] = 32'h0000_0020;
        s_wvalid = 2'b10;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("w_early_idle", {m_wvalid, s_wready, m_awvalid}, 0);
            @(posedge clk); #1;
        end
        pend_aw = 2'b10; pend_w = 2'b10; pend_b = 2'b10; aw_rdy_from = 3;
        engine(40);
        aw_rdy_from = 0;
        chk("wr_w_cyc", cyc_w[1], 1);
        chk("wr_aw_cyc", cyc_aw[1], 3);
        chk("wr_b_cyc", cyc_b[1], 4);
        chk("w_gated", trc_mw[2], 1'b0);

        // master 0 reads back 0x20 holding R off for 5 cycles while master 1 also waits
        s_araddr[31:0] = 32'h0000_0020;
        hold_exp = 32'hAAAA_5678;
        pend_ar = 2'b11; pend_r = 2'b11; rhold0 = 5;
        engine(40);
        chk("hold_left", rhold0, 0);
        chk("hold_r_cyc", cyc_r[0], 7);
        chk("hold_count", ord_q.size(), 2);
        chk("hold_ord0", ord_q[0], 0);
        chk("hold_ord1", ord_q[1], 1);
        chk("readback", dat_q[0], 32'hAAAA_5678);
        chk("m1_data", dat_q[1], 32'h5555_0005);

        // master 0 raises AR and AW together: read first, write after R
        s_araddr[31:0] = 32'h0000_0010;
        s_awaddr[31:0] = 32'h0000_0030;
        s_wdata[31:0]  = 32'h0BAD_F00D;
        s_wstrb[3:0]   = 4'hF;
        pend_ar = 2'b01; pend_r = 2'b01; pend_aw = 2'b01; pend_w = 2'b01; pend_b = 2'b01;
        engine(40);
        chk("rw_r_cyc", cyc_r[0], 2);
        chk("rw_aw_cyc", cyc_aw[0], 4);
        chk("rw_w_cyc", cyc_w[0], 4);
        chk("rw_b_cyc", cyc_b[0], 5);
        chk("rw_no_aw_early", trc_maw[3:0], 0);

        // reset while B is pending
        s_awaddr[31:0] = 32'h0000_0034;
        s_awvalid = 2'b01; s_wvalid = 2'b01; s_bready = 2'b00;
        got_b = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (s_bvalid[0]) begin
                got_b = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("b_pending", got_b, 1'b1);
        rst = 1'b1;
        #1;
        chk("rst_async", {17'h0, outs}, 0);
        s_awvalid = 2'b00; s_wvalid = 2'b00;
        @(posedge clk); #1;
        rst = 1'b0;
        pend_ar = 2'b11; pend_r = 2'b11;
        engine(40);
        chk("post_rst_cnt", ord_q.size(), 2);
        chk("post_rst_first", ord_q[0], 0);
        chk("post_rst_cyc", cyc_r[0], 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
